// File: rtl/avf_counter_bank_pkg.sv
// avfcl_pkg
// Shared definitions for the AVF event-counter bank:
//   - avf_mode_e : lane arithmetic mode (wrap modulo 2^WIDTH or clamp at all-ones)
//   - AVF_*      : default configuration constants
//   - avf_snap_t : snapshot record for the default configuration
package avfcl_pkg;

    typedef enum logic {
        AVF_WRAP = 1'b0,
        AVF_SAT  = 1'b1
    } avf_mode_e;

    localparam int AVF_NUM_CH  = 4;
    localparam int AVF_WIDTH   = 8;
    localparam int AVF_INC_W   = 3;
    localparam int AVF_EPOCH_W = 16;

    // Snapshot record for the default 4 x 8-bit configuration.
    typedef struct packed {
        logic [AVF_NUM_CH-1:0][AVF_WIDTH-1:0] count;
        logic [AVF_NUM_CH-1:0]                overflow;
    } avf_snap_t;

endpackage

// File: rtl/avf_counter_bank_if.sv
// avf_counter_bank_if
// Snapshot valid/ready channel between the counter bank and its collector.
//   snap_valid    : snapshot available (producer -> consumer)
//   snap_ready    : consumer accepts snapshot (consumer -> producer)
//   snap_count    : NUM_CH*WIDTH captured lane counts
//   snap_overflow : NUM_CH captured overflow flags
// Modports: master = counter bank, slave = collector.
interface avf_counter_bank_if
    import avfcl_pkg::*;
#(
    parameter int NUM_CH = AVF_NUM_CH,
    parameter int WIDTH  = AVF_WIDTH
);
    logic                      snap_valid;
    logic                      snap_ready;
    logic [NUM_CH*WIDTH-1:0]   snap_count;
    logic [NUM_CH-1:0]         snap_overflow;

    modport master (
        output snap_valid,
        output snap_count,
        output snap_overflow,
        input  snap_ready
    );

    modport slave (
        input  snap_valid,
        input  snap_count,
        input  snap_overflow,
        output snap_ready
    );
endinterface

// File: rtl/avf_counter_bank_lane.sv
// avf_counter_lane
// One counter lane: adder, optional saturation, sticky overflow and epoch reload.
//   clk, reset       : clock, synchronous active-high reset (loads i_seed)
//   i_enable         : advance this cycle
//   i_epoch_end      : reload i_seed instead of the updated value this cycle
//   i_inc            : unsigned increment (zero-extended)
//   i_seed           : reload / reset value
//   o_count          : live count
//   o_overflow       : sticky overflow for the current epoch
//   o_upd_count      : this cycle's post-update count (snapshot source)
//   o_upd_overflow   : this cycle's post-update overflow (snapshot source)
module avf_counter_lane
    import avfcl_pkg::*;
#(
    parameter int        WIDTH = AVF_WIDTH,
    parameter int        INC_W = AVF_INC_W,
    parameter avf_mode_e MODE  = AVF_WRAP
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_enable,
    input  logic             i_epoch_end,
    input  logic [INC_W-1:0] i_inc,
    input  logic [WIDTH-1:0] i_seed,
    output logic [WIDTH-1:0] o_count,
    output logic             o_overflow,
    output logic [WIDTH-1:0] o_upd_count,
    output logic             o_upd_overflow
);
    logic [WIDTH-1:0] r_count;
    logic             r_overflow;
    logic [WIDTH:0]   w_sum;
    logic             w_carry;

    // One extra bit so the carry-out is visible for both modes.
    assign w_sum   = {1'b0, r_count} + (WIDTH+1)'(i_inc);
    assign w_carry = w_sum[WIDTH];

    always_comb begin
        o_upd_count = w_sum[WIDTH-1:0];
        if (MODE == AVF_SAT && w_carry) begin
            o_upd_count = '1;
        end
    end

    assign o_upd_overflow = r_overflow | w_carry;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_count    <= i_seed;
            r_overflow <= 1'b0;
        end else if (i_enable) begin
            if (i_epoch_end) begin
                // Reload the bare seed; this cycle's increment went to the snapshot.
                r_count    <= i_seed;
                r_overflow <= 1'b0;
            end else begin
                r_count    <= o_upd_count;
                r_overflow <= o_upd_overflow;
            end
        end
    end

    assign o_count    = r_count;
    assign o_overflow = r_overflow;
endmodule

// File: rtl/avf_counter_bank.sv
// avf_counter_bank
// Multi-channel event-counter bank with an epoch timer that snapshots all lanes
// into a valid/ready register and re-seeds them.
//   clk, reset    : clock, synchronous active-high reset
//   enable        : lanes and epoch timer advance this cycle
//   increment     : per-lane increments, lane i at [i*INC_W +: INC_W]
//   reset_value   : per-lane seeds, used at reset and at every epoch end
//   epoch_len     : epoch length in enabled cycles, 0 disables snapshots
//   count         : live lane counts
//   overflow      : sticky per-lane overflow for the current epoch
//   snap          : snapshot channel (master side)
//   snap_dropped  : sticky, an epoch ended while the held snapshot was unaccepted
module avf_counter_bank
    import avfcl_pkg::*;
#(
    parameter int NUM_CH   = AVF_NUM_CH,
    parameter int WIDTH    = AVF_WIDTH,
    parameter int INC_W    = AVF_INC_W,
    parameter int EPOCH_W  = AVF_EPOCH_W,
    parameter int SATURATE = 0
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    enable,
    input  logic [NUM_CH*INC_W-1:0] increment,
    input  logic [NUM_CH*WIDTH-1:0] reset_value,
    input  logic [EPOCH_W-1:0]      epoch_len,
    output logic [NUM_CH*WIDTH-1:0] count,
    output logic [NUM_CH-1:0]       overflow,
    avf_counter_bank_if.master      snap,
    output logic                    snap_dropped
);
    localparam avf_mode_e LANE_MODE = (SATURATE != 0) ? AVF_SAT : AVF_WRAP;

    logic [EPOCH_W-1:0]      r_timer;
    logic                    r_snap_valid;
    logic [NUM_CH*WIDTH-1:0] r_snap_count;
    logic [NUM_CH-1:0]       r_snap_overflow;
    logic                    r_snap_dropped;

    logic                    w_epoch_end;
    logic                    w_xfer;
    logic                    w_snap_load;
    logic [NUM_CH*WIDTH-1:0] w_upd_count;
    logic [NUM_CH-1:0]       w_upd_overflow;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_lane
            avf_counter_lane #(
                .WIDTH (WIDTH),
                .INC_W (INC_W),
                .MODE  (LANE_MODE)
            ) u_lane (
                .clk            (clk),
                .reset          (reset),
                .i_enable       (enable),
                .i_epoch_end    (w_epoch_end),
                .i_inc          (increment[gi*INC_W +: INC_W]),
                .i_seed         (reset_value[gi*WIDTH +: WIDTH]),
                .o_count        (count[gi*WIDTH +: WIDTH]),
                .o_overflow     (overflow[gi]),
                .o_upd_count    (w_upd_count[gi*WIDTH +: WIDTH]),
                .o_upd_overflow (w_upd_overflow[gi])
            );
        end
    endgenerate

    assign w_epoch_end = enable && (epoch_len != '0) && (r_timer == epoch_len - EPOCH_W'(1));
    assign w_xfer      = r_snap_valid && snap.snap_ready;
    // A new snapshot lands if the register is empty or is being drained this edge.
    assign w_snap_load = w_epoch_end && (!r_snap_valid || snap.snap_ready);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_timer <= '0;
        end else if (enable && (epoch_len != '0)) begin
            // A timer beyond a shortened epoch_len just wraps at 2^EPOCH_W.
            r_timer <= w_epoch_end ? '0 : r_timer + EPOCH_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_snap_valid    <= 1'b0;
            r_snap_count    <= '0;
            r_snap_overflow <= '0;
            r_snap_dropped  <= 1'b0;
        end else begin
            if (w_snap_load) begin
                r_snap_valid    <= 1'b1;
                r_snap_count    <= w_upd_count;
                r_snap_overflow <= w_upd_overflow;
            end else if (w_xfer) begin
                r_snap_valid    <= 1'b0;
            end
            if (w_epoch_end && r_snap_valid && !snap.snap_ready) begin
                r_snap_dropped <= 1'b1;
            end
        end
    end

    assign snap.snap_valid    = r_snap_valid;
    assign snap.snap_count    = r_snap_count;
    assign snap.snap_overflow = r_snap_overflow;
    assign snap_dropped       = r_snap_dropped;
endmodule

// File: tb/tb_avf_counter_bank.sv
// Bench for avf_counter_bank: a wrap instance and a saturate instance share
// the same stimulus; a behavioural model checks both every cycle, and
// hand-computed literals pin key points of the directed sequence.
module tb_avf_counter_bank;
    import avfcl_pkg::*;

    localparam int N  = 4;
    localparam int W  = 8;
    localparam int IW = 3;
    localparam int EW = 16;

    logic            clk = 1'b0;
    logic            reset;
    logic            enable;
    logic            snap_ready;
    logic [N*IW-1:0] increment;
    logic [N*W-1:0]  reset_value;
    logic [EW-1:0]   epoch_len;

    logic [N*W-1:0]  count_w, count_s;
    logic [N-1:0]    ovf_w, ovf_s;
    logic            drop_w, drop_s;

    avf_counter_bank_if #(.NUM_CH(N), .WIDTH(W)) snap_w_if ();
    avf_counter_bank_if #(.NUM_CH(N), .WIDTH(W)) snap_s_if ();

    assign snap_w_if.snap_ready = snap_ready;
    assign snap_s_if.snap_ready = snap_ready;

    avf_counter_bank #(.NUM_CH(N), .WIDTH(W), .INC_W(IW), .EPOCH_W(EW), .SATURATE(0)) u_dut_wrap (
        .clk(clk), .reset(reset), .enable(enable), .increment(increment),
        .reset_value(reset_value), .epoch_len(epoch_len), .count(count_w),
        .overflow(ovf_w), .snap(snap_w_if.master), .snap_dropped(drop_w)
    );

    avf_counter_bank #(.NUM_CH(N), .WIDTH(W), .INC_W(IW), .EPOCH_W(EW), .SATURATE(1)) u_dut_sat (
        .clk(clk), .reset(reset), .enable(enable), .increment(increment),
        .reset_value(reset_value), .epoch_len(epoch_len), .count(count_s),
        .overflow(ovf_s), .snap(snap_s_if.master), .snap_dropped(drop_s)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model (index 0 = wrap, 1 = saturate) -------
    int m_cnt [2][N];
    bit m_ovf [2][N];
    bit m_sv  [2];
    int m_sc  [2][N];
    bit m_so  [2][N];
    bit m_sd  [2];
    int m_timer;
    bit m_live = 1'b0;

    function automatic logic [N*W-1:0] exp_cnt(input int m, input bit from_snap);
        logic [N*W-1:0] r;
        for (int i = 0; i < N; i++) begin
            r[i*W +: W] = from_snap ? W'(m_sc[m][i]) : W'(m_cnt[m][i]);
        end
        return r;
    endfunction

    function automatic logic [N-1:0] exp_ovf(input int m, input bit from_snap);
        logic [N-1:0] r;
        for (int i = 0; i < N; i++) begin
            r[i] = from_snap ? m_so[m][i] : m_ovf[m][i];
        end
        return r;
    endfunction

    task automatic model_step();
        int  len;
        bit  eend;
        int  nc [N];
        bit  no [N];
        int  s;
        if (reset) begin
            m_live  = 1'b1;
            m_timer = 0;
            for (int m = 0; m < 2; m++) begin
                for (int i = 0; i < N; i++) begin
                    m_cnt[m][i] = int'(reset_value[i*W +: W]);
                    m_ovf[m][i] = 1'b0;
                    m_sc[m][i]  = 0;
                    m_so[m][i]  = 1'b0;
                end
                m_sv[m] = 1'b0;
                m_sd[m] = 1'b0;
            end
        end else begin
            len  = int'(epoch_len);
            eend = enable && (len != 0) && (m_timer == len - 1);
            for (int m = 0; m < 2; m++) begin
                for (int i = 0; i < N; i++) begin
                    nc[i] = m_cnt[m][i];
                    no[i] = m_ovf[m][i];
                    if (enable) begin
                        s = m_cnt[m][i] + int'(increment[i*IW +: IW]);
                        if (s > 255) no[i] = 1'b1;
                        nc[i] = (m == 1) ? ((s > 255) ? 255 : s) : (s % 256);
                    end
                end
                if (eend) begin
                    if (m_sv[m] && !snap_ready) begin
                        m_sd[m] = 1'b1;
                    end else begin
                        m_sv[m] = 1'b1;
                        for (int i = 0; i < N; i++) begin
                            m_sc[m][i] = nc[i];
                            m_so[m][i] = no[i];
                        end
                    end
                end else if (m_sv[m] && snap_ready) begin
                    m_sv[m] = 1'b0;
                end
                for (int i = 0; i < N; i++) begin
                    m_cnt[m][i] = eend ? int'(reset_value[i*W +: W]) : nc[i];
                    m_ovf[m][i] = eend ? 1'b0 : no[i];
                end
            end
            if (enable && len != 0) begin
                m_timer = eend ? 0 : (m_timer + 1) % 65536;
            end
        end
    endtask

    // Compare on the falling edge, then advance the model with the inputs
    // that the next rising edge will see.
    always @(negedge clk) begin
        if (m_live) begin
            check("wrap.count",     64'(count_w),                exp_cnt(0, 1'b0));
            check("wrap.overflow",  64'(ovf_w),                  exp_ovf(0, 1'b0));
            check("wrap.snap_valid",64'(snap_w_if.snap_valid),   64'(m_sv[0]));
            check("wrap.snap_count",64'(snap_w_if.snap_count),   exp_cnt(0, 1'b1));
            check("wrap.snap_ovf",  64'(snap_w_if.snap_overflow),exp_ovf(0, 1'b1));
            check("wrap.dropped",   64'(drop_w),                 64'(m_sd[0]));
            check("sat.count",      64'(count_s),                exp_cnt(1, 1'b0));
            check("sat.overflow",   64'(ovf_s),                  exp_ovf(1, 1'b0));
            check("sat.snap_valid", 64'(snap_s_if.snap_valid),   64'(m_sv[1]));
            check("sat.snap_count", 64'(snap_s_if.snap_count),   exp_cnt(1, 1'b1));
            check("sat.snap_ovf",   64'(snap_s_if.snap_overflow),exp_ovf(1, 1'b1));
            check("sat.dropped",    64'(drop_s),                 64'(m_sd[1]));
        end
        model_step();
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // ---------------- directed stimulus with literal expectations ------------
    initial begin
        reset       = 1'b1;
        enable      = 1'b0;
        snap_ready  = 1'b0;
        epoch_len   = '0;
        increment   = '0;
        reset_value = {8'hFD, 8'h00, 8'hFE, 8'h10};

        // Reset and hold with enable low.
        repeat (3) cyc();
        check("lit.reset.count_w", 64'(count_w), 64'h00000000_FD00FE10);
        check("lit.reset.ovf_w", 64'(ovf_w), 64'h0);
        check("lit.reset.valid_w", 64'(snap_w_if.snap_valid), 64'h0);
        reset = 1'b0;
        repeat (2) cyc();
        check("lit.hold.count_s", 64'(count_s), 64'h00000000_FD00FE10);

        // Wrap / saturate: lane1 += 3, lane3 += 7.
        enable    = 1'b1;
        increment = {3'd7, 3'd0, 3'd3, 3'd0};
        cyc();
        check("lit.wrap1.count", 64'(count_w), 64'h00000000_0400_0110);
        check("lit.wrap1.ovf",   64'(ovf_w),   64'hA);
        check("lit.sat1.count",  64'(count_s), 64'h00000000_FF00FF10);
        check("lit.sat1.ovf",    64'(ovf_s),   64'hA);
        cyc();
        check("lit.wrap2.count", 64'(count_w), 64'h00000000_0B000410);
        check("lit.wrap2.ovf",   64'(ovf_w),   64'hA);
        check("lit.sat2.count",  64'(count_s), 64'h00000000_FF00FF10);

        // epoch_len=1: immediate epoch end captures post-update values.
        epoch_len = 16'd1;
        cyc();
        check("lit.snap.sat_count", 64'(snap_s_if.snap_count), 64'h00000000_FF00FF10);
        check("lit.snap.sat_ovf",   64'(snap_s_if.snap_overflow), 64'hA);
        check("lit.snap.wrap_count",64'(snap_w_if.snap_count), 64'h00000000_12000710);
        check("lit.snap.valid",     64'(snap_s_if.snap_valid), 64'h1);
        check("lit.snap.reload",    64'(count_s), 64'h00000000_FD00FE10);
        enable     = 1'b0;
        snap_ready = 1'b1;
        cyc();
        check("lit.snap.drain", 64'(snap_s_if.snap_valid), 64'h0);

        // epoch_len=4, increment 1 everywhere, always ready.
        reset       = 1'b1;
        reset_value = '0;
        increment   = {3'd1, 3'd1, 3'd1, 3'd1};
        epoch_len   = 16'd4;
        cyc();
        reset  = 1'b0;
        enable = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            cyc();
            if (k % 4 == 0) begin
                check("lit.ep4.valid", 64'(snap_w_if.snap_valid), 64'h1);
                check("lit.ep4.snap0", 64'(snap_w_if.snap_count[7:0]), 64'h4);
                check("lit.ep4.count0", 64'(count_w[7:0]), 64'h0);
            end else begin
                check("lit.ep4.idle", 64'(snap_w_if.snap_valid), 64'h0);
            end
        end

        // epoch_len=2 with back-pressure: drop, then load on a transfer edge.
        reset      = 1'b1;
        snap_ready = 1'b0;
        epoch_len  = 16'd2;
        cyc();
        reset = 1'b0;
        cyc();
        cyc();
        check("lit.bp.first", 64'(snap_w_if.snap_count[7:0]), 64'h2);
        check("lit.bp.nodrop", 64'(drop_w), 64'h0);
        increment = {3'd2, 3'd2, 3'd2, 3'd2};
        cyc();
        cyc();
        check("lit.bp.dropped", 64'(drop_w), 64'h1);
        check("lit.bp.held", 64'(snap_w_if.snap_count[7:0]), 64'h2);
        increment = {3'd3, 3'd3, 3'd3, 3'd3};
        cyc();
        snap_ready = 1'b1;
        cyc();
        check("lit.bp.reload_valid", 64'(snap_w_if.snap_valid), 64'h1);
        check("lit.bp.third", 64'(snap_w_if.snap_count[7:0]), 64'h6);
        cyc();
        check("lit.bp.drained", 64'(snap_w_if.snap_valid), 64'h0);

        // epoch_len=3 with enable toggling; reset while a snapshot is held.
        reset      = 1'b1;
        enable     = 1'b0;
        snap_ready = 1'b0;
        epoch_len  = 16'd3;
        increment  = {3'd1, 3'd1, 3'd1, 3'd1};
        cyc();
        reset = 1'b0;
        for (int k = 0; k < 12; k++) begin
            enable = (k % 2 == 0);
            cyc();
            if (k < 4) begin
                check("lit.tog.wait", 64'(snap_w_if.snap_valid), 64'h0);
            end else if (k < 6) begin
                check("lit.tog.snap", 64'(snap_w_if.snap_count[7:0]), 64'h3);
            end
        end
        check("lit.tog.dropped", 64'(drop_s), 64'h1);
        reset  = 1'b1;
        enable = 1'b1;
        snap_ready = 1'b1;
        cyc();
        check("lit.rst.valid", 64'(snap_s_if.snap_valid), 64'h0);
        check("lit.rst.snap",  64'(snap_s_if.snap_count), 64'h0);
        check("lit.rst.drop",  64'(drop_s), 64'h0);
        check("lit.rst.count", 64'(count_s), 64'h0);
        reset = 1'b0;
        repeat (3) cyc();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule

// File: doc/avf_counter_bank.md
Name: avf_counter_bank

Overview:
- Parametrised multi-channel event-counter bank for the AVF collection logic; it generalises the fixed 8-, 6- and 16-bit counters.
- Each of NUM_CH lanes accumulates a per-cycle increment, with a selectable reset value and either wrap or saturate arithmetic.
- A built-in epoch timer periodically snapshots all lanes into a valid/ready output register for the downstream collector, then re-seeds the lanes.

Parameters:
- NUM_CH, 4, number of independent counter lanes.
- WIDTH, 8, bits per lane counter.
- INC_W, 3, bits per lane increment (unsigned).
- EPOCH_W, 16, width of epoch timer and epoch_len.
- SATURATE, 0, 0 = wrap modulo 2^WIDTH, 1 = clamp at 2^WIDTH-1.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- enable  in  1  when 1, lanes and epoch timer advance this cycle.
- increment  in  NUM_CH*INC_W  lane i uses slice [i*INC_W +: INC_W].
- reset_value  in  NUM_CH*WIDTH  per-lane seed, used at reset and at every epoch end.
- epoch_len  in  EPOCH_W  epoch length in enabled cycles; 0 disables snapshots.
- count  out  NUM_CH*WIDTH  live lane counts.
- overflow  out  NUM_CH  sticky per-lane carry-out/saturation flag for the current epoch.
- snap_valid  out  1  snapshot available.
- snap_ready  in  1  consumer accepts snapshot.
- snap_count  out  NUM_CH*WIDTH  snapshot of lane counts.
- snap_overflow  out  NUM_CH  snapshot of overflow flags.
- snap_dropped  out  1  sticky: an epoch ended while the previous snapshot was unaccepted.

Behaviour:
- Reset values (reset=1 at a clock edge):
  - count = reset_value and overflow = 0.
  - Epoch timer = 0.
  - snap_valid = 0, snap_count = 0, snap_overflow = 0, snap_dropped = 0.
  - Reset has priority over every other event, including mid-handshake.
- Lane update (enable=1):
  - sum = count + increment, computed in WIDTH+1 bits.
  - Wrap mode: count = sum[WIDTH-1:0].
  - Saturate mode: count = all-ones if sum[WIDTH] is set, else sum.
  - overflow[i] is set when sum[WIDTH]=1 and stays set until epoch end or reset.
- enable=0: counts, overflow and the timer hold; the snapshot handshake still operates.
- Epoch timer:
  - Increments on each enabled cycle while epoch_len != 0.
  - Epoch end is the enabled cycle where timer == epoch_len-1.
  - At that edge the timer returns to 0.
  - epoch_len == 0: timer holds at 0, no epoch ends occur, lanes count freely.
  - If epoch_len changes so that timer >= epoch_len, the timer wraps naturally at 2^EPOCH_W; no special handling.
- At epoch end (single edge):
  - Snapshot captures the post-update values (this cycle's increment included), snap_overflow included.
  - count reloads reset_value, not reset_value+increment.
  - overflow clears.
  - snap_valid is 1 from the following cycle (1-cycle latency).
- Handshake:
  - Transfer occurs on a cycle with snap_valid & snap_ready; snap_valid drops next cycle unless a new snapshot loads at the same edge.
  - Epoch end with snap_valid=1 and snap_ready=0: new snapshot discarded, held snapshot unchanged, snap_dropped set (cleared only by reset). Lanes still reload.
  - Epoch end coinciding with a transfer: new snapshot loads and snap_valid stays 1.
  - snap_count and snap_overflow are stable while snap_valid=1 and snap_ready=0.
- Widths: increment is zero-extended. epoch_len=1 gives an epoch end on every enabled cycle.

Decomposition:
- Package avfcl_pkg holds:
  - the count-mode enum (AVF_WRAP, AVF_SAT);
  - default width constants (WIDTH 8, INC_W 3, EPOCH_W 16);
  - a snapshot struct typedef helper for the default configuration.
- One sub-module, avf_counter_lane:
  - contains one lane's adder, saturation, sticky overflow and reload mux;
  - is generated NUM_CH times.
- The epoch timer and snapshot register live in the top module.

Test Plan:
- Reset with reset_value lane0=8'h10, lane1=8'hFE, enable=0 -> count={..,FE,10}, overflow=0, snap_valid=0 for all held cycles.
- Wrap mode, lane1 seed FE, increment 3 for one cycle -> lane1=8'h01, overflow[1]=1; further increments leave overflow[1]=1.
- SATURATE=1, seed FD, increment 7 twice -> lane=FF both cycles, overflow=1; snapshot shows FF and overflow=1.
- epoch_len=4, increment 1, seed 0, enable constant, snap_ready=1 -> snap_valid pulses one cycle after every 4th cycle with snap_count=4; count reads 0 the cycle after each epoch end.
- snap_ready=0, epoch_len=2 -> first snapshot held unchanged, snap_dropped=1 after the second epoch end. Then assert snap_ready together with the third epoch end -> third snapshot loads, snap_valid stays 1.
- Toggle enable 1/0 alternately, epoch_len=3 -> epoch end after 3 enabled cycles (6 clocks). Assert reset while snap_valid=1 -> all outputs return to reset values the next cycle.
